search_seq: RTL and testbench

- Sequencing controller for the 8-bit-address, 8-bit-data single-port pattern-search BRAM (`blk_mem_gen_0`, 1-cycle read latency).
- Issues BRAM read addresses and compares returned bytes against a 1..MAX_PAT byte pattern, using a naive restart search over a base/length window.
- Reports the first match with a start/done handshake; `resume` continues the search after the last match.
- Owns the BRAM read port while busy and replaces the combinational search loop.

---
 rtl/search_seq.sv | 145 ++++++++++++++
 tb/tb_search_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/search_seq.sv
// Sequencing controller for pattern search over a 1-cycle-latency BRAM read port.
// Define SEARCH_SEQ_MATCH_COUNT_EN to add the saturating match_count output.
module search_seq #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int MAX_PAT = 4
) (
  input  logic                      CLK100MHZ,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      resume,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [ADDR_W-1:0]         block_len,
  input  logic [2:0]                pat_len,
  input  logic [MAX_PAT*DATA_W-1:0] pattern,
  output logic                      mem_en,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_dout,
  output logic                      busy,
  output logic                      done,
  output logic                      found,
`ifdef SEARCH_SEQ_MATCH_COUNT_EN
  output logic [ADDR_W-1:0]         match_count,
`endif
  output logic [ADDR_W-1:0]         match_addr
);

  localparam int JW = (MAX_PAT > 1) ? $clog2(MAX_PAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, CMP, FIN} state_t;

  state_t                      state;
  logic [ADDR_W-1:0]           cand;
  logic [ADDR_W-1:0]           last;
  logic [JW-1:0]               j;
  logic [2:0]                  plen;
  logic [MAX_PAT*DATA_W-1:0]   pat_r;
  logic [MAX_PAT*DATA_W-1:0]   pat_sh;
  logic                        j_last;
  logic                        bad_req;

  assign j_last  = (int'(j) + 1 == int'(plen));
  assign bad_req = (pat_len == 3'd0) || (int'(pat_len) > MAX_PAT) ||
                   (block_len < ADDR_W'(pat_len));

  // pat_sh holds the pattern shifted so byte j sits in the low DATA_W bits,
  // avoiding a variable part-select on the compare path.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mem_en     <= 1'b0;
      mem_addr   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      found      <= 1'b0;
      match_addr <= '0;
      cand       <= '0;
      last       <= '0;
      j          <= '0;
      plen       <= '0;
      pat_r      <= '0;
      pat_sh     <= '0;
`ifdef SEARCH_SEQ_MATCH_COUNT_EN
      match_count <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            found      <= 1'b0;
            match_addr <= '0;
            pat_r      <= pattern;
            pat_sh     <= pattern;
            plen       <= pat_len;
            last       <= base_addr + block_len - ADDR_W'(pat_len);
            cand       <= base_addr;
            j          <= '0;
`ifdef SEARCH_SEQ_MATCH_COUNT_EN
            match_count <= '0;
`endif
            if (bad_req) begin
              state <= FIN;
            end else begin
              busy     <= 1'b1;
              mem_en   <= 1'b1;
              mem_addr <= base_addr;
              state    <= ISSUE;
            end
          end else if (resume && found) begin
            found      <= 1'b0;
            match_addr <= '0;
            cand       <= match_addr + 1'b1;
            j          <= '0;
            pat_sh     <= pat_r;
            busy       <= 1'b1;
            if (match_addr == last) begin
              state <= FIN;
            end else begin
              mem_en   <= 1'b1;
              mem_addr <= match_addr + 1'b1;
              state    <= ISSUE;
            end
          end
        end
        ISSUE: state <= CMP;
        CMP: begin
          if (mem_dout == pat_sh[DATA_W-1:0]) begin
            if (j_last) begin
              found      <= 1'b1;
              match_addr <= cand;
              mem_en     <= 1'b0;
              state      <= FIN;
`ifdef SEARCH_SEQ_MATCH_COUNT_EN
              if (match_count != '1) match_count <= match_count + 1'b1;
`endif
            end else begin
              j        <= j + 1'b1;
              pat_sh   <= pat_sh >> DATA_W;
              mem_addr <= cand + ADDR_W'(j) + 1'b1;
              state    <= ISSUE;
            end
          end else if (cand == last) begin
            mem_en <= 1'b0;
            state  <= FIN;
          end else begin
            cand     <= cand + 1'b1;
            j        <= '0;
            pat_sh   <= pat_r;
            mem_addr <= cand + 1'b1;
            state    <= ISSUE;
          end
        end
        FIN: begin
          done   <= 1'b1;
          busy   <= 1'b0;
          mem_en <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_search_seq.sv
// Directed bench for search_seq with a behavioural 1-cycle-latency BRAM.
module tb_search_seq;
  logic        clk = 1'b0;
  logic        rst, start, resume;
  logic [7:0]  base_addr, block_len;
  logic [2:0]  pat_len;
  logic [31:0] pattern;
  logic        mem_en;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_dout = 8'h00;
  logic        busy, done, found;
  logic [7:0]  match_addr;
`ifdef SEARCH_SEQ_MATCH_COUNT_EN
  logic [7:0]  match_count;
`endif

  int total = 0;
  int bad   = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  logic [7:0] aq[$];
  logic [7:0] mem [256];

  search_seq #(.ADDR_W(8), .DATA_W(8), .MAX_PAT(4)) dut (
    .CLK100MHZ (clk),
    .reset     (rst),
    .start     (start),
    .resume    (resume),
    .base_addr (base_addr),
    .block_len (block_len),
    .pat_len   (pat_len),
    .pattern   (pattern),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .busy      (busy),
    .done      (done),
    .found     (found),
`ifdef SEARCH_SEQ_MATCH_COUNT_EN
    .match_count (match_count),
`endif
    .match_addr(match_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      mem_dout <= mem[mem_addr];
      en_cnt++;
      if (aq.size() == 0 || aq[$] != mem_addr) aq.push_back(mem_addr);
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues start (or resume) and counts edges until done, starting from the sampling edge.
  task automatic run(input logic is_resume, input logic [7:0] b, input logic [7:0] l,
                     input logic [2:0] pl, input logic [31:0] p,
                     output int edges, output logic busy0);
    @(negedge clk);
    base_addr = b; block_len = l; pat_len = pl; pattern = p;
    if (is_resume) resume = 1'b1; else start = 1'b1;
    edges = 0;
    busy0 = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      start = 1'b0; resume = 1'b0;
      if (k == 0) busy0 = busy;
      if (done) break;
      edges++;
    end
  endtask

  task automatic after_done(input string tag);
    @(negedge clk);
    check({tag, "_done_width"}, {31'd0, done}, 32'd0);
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  int   e;
  logic b0;
  int   en0, d0, q0;
  logic seen;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h11; mem[8'h11] = 8'hAA; mem[8'h12] = 8'hBB; mem[8'h13] = 8'hCC;
    mem[8'h14] = 8'h22; mem[8'h15] = 8'h33; mem[8'h16] = 8'h44; mem[8'h17] = 8'h55;
    mem[8'h20] = 8'hAB; mem[8'h21] = 8'hAB; mem[8'h22] = 8'hAB;
    mem[8'hFF] = 8'h5A; mem[8'h00] = 8'hA5;
    rst = 1'b1; start = 1'b0; resume = 1'b0;
    base_addr = '0; block_len = '0; pat_len = '0; pattern = '0;
    repeat (2) @(negedge clk);
    check("rst_outs", {26'd0, mem_en, busy, done, found, 2'b00},  32'd0);
    check("rst_addrs", {16'd0, mem_addr, match_addr}, 32'd0);
    rst = 1'b0;

    // Match at 0x12 after three candidates (4 bytes examined -> done at edge 9).
    run(1'b0, 8'h10, 8'd8, 3'd2, 32'h0000_CCBB, e, b0);
    check("m1_busy", {31'd0, b0}, 32'd1);
    check("m1_edges", e, 9);
    check("m1_found", {31'd0, found}, 32'd1);
    check("m1_addr", {24'd0, match_addr}, 32'h12);
    after_done("m1");

    // No match: 8 single-byte candidates -> done at edge 17.
    run(1'b0, 8'h10, 8'd8, 3'd1, 32'h0000_00EE, e, b0);
    check("nm_edges", e, 17);
    check("nm_found", {31'd0, found}, 32'd0);
    check("nm_addr", {24'd0, match_addr}, 32'h00);
    after_done("nm");

    // Resume after a failed search must be ignored.
    en0 = en_cnt; d0 = done_cnt;
    @(negedge clk); resume = 1'b1;
    @(negedge clk); resume = 1'b0;
    repeat (4) @(negedge clk);
    check("rs_ign_done", done_cnt - d0, 0);
    check("rs_ign_en", en_cnt - en0, 0);

    // Overlapping matches via resume.
    run(1'b0, 8'h20, 8'd6, 3'd2, 32'h0000_ABAB, e, b0);
    check("r0_edges", e, 5);
    check("r0_addr", {23'd0, found, match_addr}, 32'h120);
    run(1'b1, 8'h00, 8'd0, 3'd0, 32'h0, e, b0);
    check("r1_edges", e, 5);
    check("r1_addr", {23'd0, found, match_addr}, 32'h121);
    run(1'b1, 8'h00, 8'd0, 3'd0, 32'h0, e, b0);
    check("r2_edges", e, 9);
    check("r2_found", {23'd0, found, match_addr}, 32'h000);
`ifdef SEARCH_SEQ_MATCH_COUNT_EN
    check("r_count", {24'd0, match_count}, 32'd2);
`endif

    // Invalid requests: done one edge after sampling, port untouched.
    en0 = en_cnt;
    run(1'b0, 8'h10, 8'd8, 3'd0, 32'h0000_00BB, e, b0);
    check("inv0_edges", e, 1);
    check("inv0_found", {31'd0, found}, 32'd0);
    check("inv0_busy", {31'd0, b0}, 32'd0);
    run(1'b0, 8'h10, 8'd1, 3'd3, 32'h00CC_BB11, e, b0);
    check("inv1_edges", e, 1);
    check("inv1_found", {31'd0, found}, 32'd0);
    run(1'b0, 8'h10, 8'd8, 3'd5, 32'h0000_00BB, e, b0);
    check("inv2_edges", e, 1);
    check("inv_en", en_cnt - en0, 0);

    // Window wrapping through 0xFF -> 0x00.
    q0 = aq.size();
    run(1'b0, 8'hFE, 8'd4, 3'd2, 32'h0000_A55A, e, b0);
    check("wr_edges", e, 7);
    check("wr_addr", {23'd0, found, match_addr}, 32'h1FF);
    seen = 1'b0;
    for (int k = q0; k + 1 < aq.size(); k++)
      if (aq[k] == 8'hFF && aq[k+1] == 8'h00) seen = 1'b1;
    check("wr_seq", {31'd0, seen}, 32'd1);

    // Reset in the middle of a long scan.
    @(negedge clk);
    base_addr = 8'h40; block_len = 8'd200; pat_len = 3'd2; pattern = 32'h0000_EEEE;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check("mr_outs", {26'd0, mem_en, busy, done, found, 2'b00}, 32'd0);
    check("mr_addrs", {16'd0, mem_addr, match_addr}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("mr_nodone", done_cnt - d0, 0);
    run(1'b0, 8'h10, 8'd8, 3'd2, 32'h0000_CCBB, e, b0);
    check("mr_edges", e, 9);
    check("mr_addr", {23'd0, found, match_addr}, 32'h112);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
